// File: rtl/game_round_ctrl.sv
// Round controller for a button-mashing game: latches a player, counts hit
// rising edges during a tick-timed round, then pulses done with the final score.
module game_round_ctrl #(
    parameter int ROUND_TICKS = 30,
    parameter int HIT_CAP     = 255
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       start,
    input  logic       hit,
    input  logic       tick,
    input  logic [2:0] user_sel,
    output logic [7:0] enable,
    output logic [7:0] score_count,
    output logic [2:0] user_id,
    output logic [7:0] time_left,
    output logic       done,
    output logic       busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [7:0] TICKS_INIT = 8'(ROUND_TICKS);
    localparam logic [7:0] SCORE_MAX  = 8'(HIT_CAP);

    logic [1:0] state;
    logic       hit_q;
    logic       hit_rise;

    assign hit_rise = hit & ~hit_q;

    // NOTE: all state is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others within the same edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state       <= IDLE;
            hit_q       <= 1'b0;
            enable      <= 8'd0;
            score_count <= 8'd0;
            user_id     <= 3'd0;
            time_left   <= 8'd0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Tracking hit every cycle also primes the edge detector on start.
            hit_q <= hit;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        user_id     <= user_sel;
                        score_count <= 8'd0;
                        time_left   <= TICKS_INIT;
                        enable      <= 8'd1 << user_sel;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    if (hit_rise && (score_count < SCORE_MAX)) begin
                        score_count <= score_count + 8'd1;
                    end
                    if (tick) begin
                        time_left <= time_left - 8'd1;
                        if (time_left == 8'd1) begin
                            state  <= DONE;
                            enable <= 8'd0;
                            done   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    enable <= 8'd0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Scoreboard bench for game_round_ctrl: stimulus enqueues the expected final
// result of each round, a monitor pops and compares on every done pulse.
module tb_game_round_ctrl;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       start;
    logic       hit;
    logic       tick;
    logic [2:0] user_sel;
    logic [7:0] enable;
    logic [7:0] score_count;
    logic [2:0] user_id;
    logic [7:0] time_left;
    logic       done;
    logic       busy;

    typedef struct {
        logic [7:0] score;
        logic [2:0] uid;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    game_round_ctrl #(.ROUND_TICKS(3), .HIT_CAP(255)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .hit        (hit),
        .tick       (tick),
        .user_sel   (user_sel),
        .enable     (enable),
        .score_count(score_count),
        .user_id    (user_id),
        .time_left  (time_left),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] sel);
        start    = 1'b1;
        user_sel = sel;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        cyc();
        hit = 1'b0;
        cyc();
    endtask

    task automatic tick_once();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (clr_n && done) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_score", 32'(score_count), 32'(e.score));
                check("sb_user_id", 32'(user_id), 32'(e.uid));
                check("sb_time_left", 32'(time_left), 32'd0);
                check("sb_enable_off", 32'(enable), 32'd0);
                check("sb_busy", 32'(busy), 32'd1);
            end
        end
    end

    initial begin
        clr_n    = 1'b0;
        start    = 1'b0;
        hit      = 1'b0;
        tick     = 1'b0;
        user_sel = 3'd0;
        cyc();
        cyc();
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_score", 32'(score_count), 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_time_uid", {21'd0, user_id, time_left}, 32'd0);
        clr_n = 1'b1;
        cyc();

        // Basic round: player 5, four hits, three ticks.
        do_start(3'd5);
        check("run_enable", 32'(enable), 32'h20);
        check("run_time_left", 32'(time_left), 32'd3);
        check("run_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) pulse_hit();
        check("run_score4", 32'(score_count), 32'd4);
        exp_q.push_back('{score: 8'd4, uid: 3'd5});
        tick_once();
        tick_once();
        check("run_time_left1", 32'(time_left), 32'd1);
        tick_once();
        check("done_pulse", 32'(done), 32'd1);
        cyc();
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_enable", 32'(enable), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_score_hold", 32'(score_count), 32'd4);

        // Held hit counts once.
        do_start(3'd2);
        hit = 1'b1;
        repeat (10) cyc();
        hit = 1'b0;
        cyc();
        check("held_hit_once", 32'(score_count), 32'd1);
        exp_q.push_back('{score: 8'd1, uid: 3'd2});
        repeat (3) tick_once();
        cyc();

        // Saturation at HIT_CAP with 300 edges.
        do_start(3'd0);
        for (int i = 0; i < 300; i++) pulse_hit();
        check("saturate_255", 32'(score_count), 32'd255);
        exp_q.push_back('{score: 8'd255, uid: 3'd0});
        repeat (3) tick_once();
        cyc();

        // Ignored mid-run start, then hit coincident with final tick.
        do_start(3'd3);
        for (int i = 0; i < 7; i++) pulse_hit();
        tick_once();
        start    = 1'b1;
        user_sel = 3'd6;
        cyc();
        start = 1'b0;
        check("restart_time_left", 32'(time_left), 32'd2);
        check("restart_score", 32'(score_count), 32'd7);
        check("restart_user_id", 32'(user_id), 32'd3);
        check("restart_enable", 32'(enable), 32'h08);
        tick_once();
        exp_q.push_back('{score: 8'd8, uid: 3'd3});
        hit  = 1'b1;
        tick = 1'b1;
        cyc();
        hit  = 1'b0;
        tick = 1'b0;
        check("coinc_done", 32'(done), 32'd1);
        check("coinc_score", 32'(score_count), 32'd8);
        cyc();

        // Hit and tick in IDLE change nothing.
        hit  = 1'b1;
        tick = 1'b1;
        cyc();
        hit  = 1'b0;
        tick = 1'b0;
        cyc();
        check("idle_hit_ignored", 32'(score_count), 32'd8);
        check("idle_tick_ignored", 32'(time_left), 32'd0);
        check("idle_uid_hold", 32'(user_id), 32'd3);

        // Reset mid-run aborts the round.
        do_start(3'd1);
        for (int i = 0; i < 6; i++) pulse_hit();
        check("pre_reset_score", 32'(score_count), 32'd6);
        clr_n = 1'b0;
        #1;
        check("abort_score", 32'(score_count), 32'd0);
        check("abort_enable", 32'(enable), 32'd0);
        check("abort_busy_done", {30'd0, busy, done}, 32'd0);
        check("abort_time_uid", {21'd0, user_id, time_left}, 32'd0);
        cyc();
        cyc();
        clr_n = 1'b1;
        cyc();
        check("post_reset_idle", {23'd0, busy, enable}, 32'd0);

        // A fresh round still works after the abort.
        do_start(3'd4);
        check("post_reset_enable", 32'(enable), 32'h10);
        exp_q.push_back('{score: 8'd0, uid: 3'd4});
        repeat (3) tick_once();
        repeat (3) cyc();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 SHALL have parameter ROUND_TICKS, default 30: tick pulses per round; legal range 1..255.
REQ-002 SHALL have parameter HIT_CAP, default 255: score saturation value; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 clr_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  synchronous one-cycle request to begin a round.
REQ-006 hit  input  1  debounced, synchronous player button level.
REQ-007 tick  input  1  one-cycle timebase strobe, e.g. 1 Hz.
REQ-008 user_sel  input  3  player number for the next round.
REQ-009 enable  output  8  one-hot of the active player during RUN; all zero otherwise.
REQ-010 score_count  output  8  hit count for the current or most recent round.
REQ-011 user_id  output  3  player number latched at round start.
REQ-012 time_left  output  8  ticks remaining in the round.
REQ-013 done  output  1  one-cycle pulse marking a committed final score.
REQ-014 busy  output  1  high in RUN and DONE.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE, one transition per clock edge at most.
REQ-016 IDLE with start=1 SHALL go to RUN on the next edge.
- Same edge: user_id<=user_sel, score_count<=0, time_left<=ROUND_TICKS, hit edge detector primed with the current hit level.
REQ-017 In RUN, enable SHALL equal 8'b1<<user_id; enable SHALL be 0 in IDLE and DONE.
REQ-018 In RUN, a hit rising edge (hit=1 with the previous-cycle hit=0) SHALL increment score_count by 1.
- Held levels and falling edges SHALL not count.
REQ-019 score_count SHALL saturate at HIT_CAP; further edges leave it unchanged, with no wrap.
REQ-020 In RUN, tick=1 SHALL decrement time_left by 1.
- When tick=1 and time_left==1, time_left SHALL become 0 and the state SHALL go to DONE on that edge.
REQ-021 A hit edge and the final tick in the same cycle SHALL both take effect: the hit is counted and DONE is entered.
REQ-022 start in RUN or DONE SHALL be ignored, with no restart and no reload.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-024 score_count, user_id and time_left (=0) SHALL hold their values from DONE through IDLE until the next accepted start.
- The downstream consumer samples score_count on the cycle enable falls to zero.
REQ-025 In IDLE and DONE, hit and tick SHALL have no effect on score_count or time_left.
REQ-026 done and enable SHALL be registered outputs, free of combinational paths from inputs.
REQ-027 user_sel SHALL be sampled only on the accepted start edge; later changes SHALL not alter user_id.

Reset
REQ-028 While clr_n=0, the following SHALL be forced asynchronously:
- state=IDLE, enable=0, score_count=0, user_id=0, time_left=0, done=0, busy=0, hit history=0.
REQ-029 Reset asserted mid-RUN SHALL abort the round with no done pulse, and the partial score SHALL be discarded.
REQ-030 After clr_n rises, the first accepted start SHALL be no earlier than the first rising edge with clr_n=1.

Verification
REQ-031 ROUND_TICKS=3, start with user_sel=5, 4 hit pulses, then 3 ticks -> enable=8'h20 during RUN; score_count=4; done high 1 cycle; enable=0 afterwards; score_count holds 4.
REQ-032 Hit held high for 10 cycles in RUN -> score_count increments by exactly 1.
REQ-033 HIT_CAP=255, 300 hit edges in RUN -> score_count=255, with no wrap to 44.
REQ-034 Hit edge coincident with the final tick, starting from score 7 -> final score_count=8 and done asserted on the same edge.
REQ-035 start pulsed mid-RUN with time_left=2 and user_sel changed -> time_left, score_count and user_id are unchanged.
REQ-036 clr_n driven low mid-RUN with score=6 -> all outputs are 0 immediately, no done pulse occurs, and the state is IDLE after release.
